// File: rtl/lf_spi_pkg.sv
// Shared command codes, major-mode codes and frame geometry for the LF SPI
// command receiver.
package lf_spi_pkg;

    localparam int CMD_NOP                   = 0;
    localparam int SET_CONFREG               = 1;
    localparam int SET_DIVISOR               = 2;
    localparam int SET_EDGE_DETECT_THRESHOLD = 3;

    typedef enum logic [2:0] {
        MM_MODE0 = 3'd0,
        MM_MODE1 = 3'd1,
        MM_MODE2 = 3'd2,
        MM_MODE3 = 3'd3,
        MM_OFF   = 3'd7
    } major_mode_e;

    function automatic int frame_w(input int cmd_w, input int data_w);
        return cmd_w + data_w;
    endfunction

    // READ is the all-ones command for whatever command width is in use
    function automatic int cmd_read(input int cmd_w);
        return (1 << cmd_w) - 1;
    endfunction

endpackage

// File: rtl/lf_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a prev-flop
// that yields single-cycle rise/fall pulses on the synchronised level.
module lf_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    // Chain and prev both reset to the pin's idle level so reset itself
    // never produces an edge.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= {SYNC_STAGES{INIT}};
            prev_reg <= INIT;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/lf_spi_cmd_regs.sv
// Oversampled SPI command receiver: validates frame length, decodes commands
// into configuration registers, and shifts register readback out on miso.
module lf_spi_cmd_regs
    import lf_spi_pkg::*;
#(
    parameter int CMD_W             = 4,
    parameter int DATA_W            = 12,
    parameter int NUM_REGS          = 3,
    parameter int SYNC_STAGES       = 2,
    parameter int ED_THRESH_DEFAULT = 127,
    parameter int ED_MAJOR_MODE     = 1
) (
    input  logic                       pck0,
    input  logic                       rst,
    input  logic                       spck,
    input  logic                       ncs,
    input  logic                       mosi,
    output logic                       miso,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [2:0]                 major_mode,
    output logic                       cmd_strobe,
    output logic [CMD_W-1:0]           cmd_code,
    output logic                       frame_err,
    output logic [7:0]                 err_count
);

    localparam int               FRAME_W = frame_w(CMD_W, DATA_W);
    localparam int               CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CMD_W-1:0] CMD_RD  = CMD_W'(cmd_read(CMD_W));
    localparam logic [2:0]       PIN_IDLE = 3'b010;

    logic [2:0] pin_vec, pin_s, pin_rise, pin_fall;
    assign pin_vec = {mosi, ncs, spck};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        lf_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES),
            .INIT       (PIN_IDLE[gi])
        ) u_sync (
            .clk  (pck0),
            .srst (rst),
            .din  (pin_vec[gi]),
            .level(pin_s[gi]),
            .rise (pin_rise[gi]),
            .fall (pin_fall[gi])
        );
    end

    logic unused_edges;
    assign unused_edges = &{1'b0, pin_fall[0], pin_rise[2], pin_fall[2]};

    logic spck_rise, ncs_s, ncs_rise, ncs_fall, mosi_s;
    assign spck_rise = pin_rise[0];
    assign ncs_s     = pin_s[1];
    assign ncs_rise  = pin_rise[1];
    assign ncs_fall  = pin_fall[1];
    assign mosi_s    = pin_s[2];

    logic                armed_reg, pending_reg, miso_reg;
    logic [CNT_W-1:0]    bitcnt_reg;
    logic [FRAME_W-1:0]  shift_reg, tx_reg;
    logic [DATA_W-1:0]   rb_reg;
    logic                cmd_strobe_reg, frame_err_reg;
    logic [CMD_W-1:0]    cmd_code_reg;
    logic [7:0]          err_count_reg;

    logic [CMD_W-1:0]    cmd;
    logic [DATA_W-1:0]   data;
    logic [3:0]          rd_idx;
    logic                capture, frame_end;
    assign cmd       = shift_reg[FRAME_W-1 -: CMD_W];
    assign data      = shift_reg[DATA_W-1:0];
    assign rd_idx    = data[3:0];
    // ncs_s is high on a rising ncs edge, so a coincident spck edge is dropped
    assign capture   = spck_rise & ~ncs_s & armed_reg;
    assign frame_end = ncs_rise & armed_reg;

    logic                accept, reject, autoload, rd_en;
    logic [NUM_REGS-1:0] wr_en;
    logic [DATA_W-1:0]   rd_val;

    always_comb begin
        accept   = 1'b0;
        reject   = 1'b0;
        autoload = 1'b0;
        rd_en    = 1'b0;
        wr_en    = '0;
        rd_val   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rd_idx) == i) rd_val = regs_flat[i*DATA_W +: DATA_W];
        end
        if (frame_end) begin
            if (bitcnt_reg != CNT_W'(FRAME_W)) begin
                reject = 1'b1;
            end else if (cmd == CMD_RD) begin
                if (int'(rd_idx) < NUM_REGS) begin
                    accept = 1'b1;
                    rd_en  = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end else if (int'(cmd) == CMD_NOP) begin
                accept = 1'b1;
            end else if (int'(cmd) <= NUM_REGS) begin
                accept = 1'b1;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (int'(cmd) == i + 1) wr_en[i] = 1'b1;
                end
                autoload = (NUM_REGS >= 3) && (int'(cmd) == SET_CONFREG) &&
                           (data[7:5] == 3'(ED_MAJOR_MODE));
            end else begin
                reject = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [DATA_W-1:0] RST_VAL = (gi == 2) ? DATA_W'(ED_THRESH_DEFAULT) : '0;
        logic [DATA_W-1:0] val_reg;

        always_ff @(posedge pck0) begin
            if (rst) begin
                val_reg <= RST_VAL;
            end else if (wr_en[gi]) begin
                val_reg <= data;
            end else if (autoload && gi == 2) begin
                val_reg <= DATA_W'(ED_THRESH_DEFAULT);
            end
        end

        assign regs_flat[gi*DATA_W +: DATA_W] = val_reg;
    end

    always_ff @(posedge pck0) begin
        if (rst) begin
            armed_reg      <= 1'b0;
            pending_reg    <= 1'b0;
            miso_reg       <= 1'b0;
            bitcnt_reg     <= '0;
            shift_reg      <= '0;
            tx_reg         <= '0;
            rb_reg         <= '0;
            cmd_strobe_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            cmd_code_reg   <= '0;
            err_count_reg  <= '0;
        end else begin
            cmd_strobe_reg <= accept;
            frame_err_reg  <= reject;
            if (accept) cmd_code_reg <= cmd;
            if (reject && err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;

            if (ncs_fall) begin
                armed_reg   <= 1'b1;
                bitcnt_reg  <= '0;
                tx_reg      <= pending_reg ? {{CMD_W{1'b0}}, rb_reg} : '0;
                pending_reg <= 1'b0;
            end else if (capture) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], mosi_s};
                if (bitcnt_reg != CNT_W'(FRAME_W + 1)) bitcnt_reg <= bitcnt_reg + CNT_W'(1);
                tx_reg    <= {tx_reg[FRAME_W-2:0], 1'b0};
                miso_reg  <= tx_reg[FRAME_W-1];
            end

            if (frame_end) armed_reg <= 1'b0;
            // A newer READ simply replaces an unconsumed readback
            if (rd_en) begin
                rb_reg      <= rd_val;
                pending_reg <= 1'b1;
            end
        end
    end

    assign miso       = miso_reg;
    assign major_mode = regs_flat[7:5];
    assign cmd_strobe = cmd_strobe_reg;
    assign cmd_code   = cmd_code_reg;
    assign frame_err  = frame_err_reg;
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_lf_spi_cmd_regs.sv
// Bench for lf_spi_cmd_regs: directed vector table, reset-mid-frame sequence,
// randomized frames against a reference model, and error-counter saturation.
module tb_lf_spi_cmd_regs;

    localparam int CMD_W    = 4;
    localparam int DATA_W   = 12;
    localparam int NUM_REGS = 3;

    logic        pck0 = 1'b0;
    logic        rst  = 1'b1;
    logic        spck = 1'b0;
    logic        ncs  = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [35:0] regs_flat;
    logic [2:0]  major_mode;
    logic        cmd_strobe;
    logic [3:0]  cmd_code;
    logic        frame_err;
    logic [7:0]  err_count;

    always #5 pck0 = ~pck0;

    lf_spi_cmd_regs #(
        .CMD_W(CMD_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
        .SYNC_STAGES(2), .ED_THRESH_DEFAULT(127), .ED_MAJOR_MODE(1)
    ) dut (
        .pck0(pck0), .rst(rst), .spck(spck), .ncs(ncs), .mosi(mosi),
        .miso(miso), .regs_flat(regs_flat), .major_mode(major_mode),
        .cmd_strobe(cmd_strobe), .cmd_code(cmd_code),
        .frame_err(frame_err), .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int ferr_cnt = 0;

    // Pulses are counted per cycle, so a stretched pulse shows up as an extra count
    always @(negedge pck0) begin
        if (cmd_strobe) strobe_cnt++;
        if (frame_err)  ferr_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge pck0);
    endtask

    // Shifts nbits of bits out MSB-first; miso is sampled once per bit,
    // just before the following spck rise (or before ncs rises).
    task automatic send_bits(input logic [31:0] bits, input int nbits, output logic [31:0] cap);
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = bits[nbits-1-i];
            cyc(4);
            @(negedge pck0);
            if (i > 0) cap = {cap[30:0], miso};
            spck = 1'b1;
            cyc(4);
            spck = 1'b0;
        end
        cyc(4);
        @(negedge pck0);
        if (nbits > 0) cap = {cap[30:0], miso};
    endtask

    task automatic spi_frame(input logic [31:0] bits, input int nbits, output logic [31:0] cap);
        ncs = 1'b0;
        cyc(6);
        send_bits(bits, nbits, cap);
        ncs  = 1'b1;
        mosi = 1'b0;
        cyc(8);
    endtask

    // miso stream expected for an n-bit frame whose tx word is tx
    function automatic logic [31:0] exp_shift(input logic [15:0] tx, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (i < 16) r = {r[30:0], tx[15-i]};
            else        r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // Reference model: register file, readback buffer and error counter as plain variables
    logic [11:0] m_regs [3];
    int          m_err;
    bit          m_pend;
    logic [11:0] m_rb;
    logic [3:0]  m_code;

    task automatic model_reset();
        m_regs[0] = 12'd0;
        m_regs[1] = 12'd0;
        m_regs[2] = 12'd127;
        m_err  = 0;
        m_pend = 1'b0;
        m_rb   = '0;
        m_code = '0;
    endtask

    task automatic model_frame(input logic [31:0] bits, input int nbits,
                               output bit acc, output bit rej, output logic [31:0] exp_m);
        logic [15:0] tx;
        int          c;
        logic [11:0] d;
        tx     = m_pend ? {4'h0, m_rb} : 16'h0;
        m_pend = 1'b0;
        exp_m  = exp_shift(tx, nbits);
        acc = 1'b0;
        rej = 1'b0;
        c = int'(bits[15:12]);
        d = bits[11:0];
        if (nbits != 16) begin
            rej = 1'b1;
        end else if (c == 15) begin
            if (int'(d[3:0]) < NUM_REGS) begin
                acc = 1'b1;
                m_rb = m_regs[d[3:0]];
                m_pend = 1'b1;
            end else begin
                rej = 1'b1;
            end
        end else if (c == 0) begin
            acc = 1'b1;
        end else if (c <= NUM_REGS) begin
            acc = 1'b1;
            m_regs[c-1] = d;
            if (c == 1 && d[7:5] == 3'd1) m_regs[2] = 12'd127;
        end else begin
            rej = 1'b1;
        end
        if (acc) m_code = bits[15:12];
        if (rej && m_err < 255) m_err++;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] bits, input int nbits);
        int          s0, f0;
        logic [31:0] cap, exp_m;
        bit          acc, rej;
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        spi_frame(bits, nbits, cap);
        model_frame(bits, nbits, acc, rej, exp_m);
        @(negedge pck0);
        $display("frame %s bits=0x%0h n=%0d strobe=%0d err=%0d miso=0x%0h",
                 tag, bits, nbits, strobe_cnt - s0, ferr_cnt - f0, cap);
        check({tag, " strobe"},    64'(strobe_cnt - s0), 64'(acc));
        check({tag, " frame_err"}, 64'(ferr_cnt - f0), 64'(rej));
        check({tag, " cmd_code"},  64'(cmd_code), 64'(m_code));
        check({tag, " regs"},      64'(regs_flat), 64'({m_regs[2], m_regs[1], m_regs[0]}));
        check({tag, " err_count"}, 64'(err_count), 64'(m_err));
        check({tag, " miso"},      64'(cap), 64'(exp_m));
    endtask

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        bit          strobe;
        bit          ferr;
        logic [3:0]  code;
        logic [35:0] regs;
        logic [15:0] miso;
        logic [7:0]  errs;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int          s0, f0;
        logic [31:0] cap;
        logic [31:0] rbits;
        int          rn;
        int          sel;

        tbl[0]  = '{32'h3050,  16, 1, 0, 4'h3, {12'h050, 12'h000, 12'h000}, 16'h0000, 8'd0};
        tbl[1]  = '{32'h1021,  16, 1, 0, 4'h1, {12'h07F, 12'h000, 12'h021}, 16'h0000, 8'd0};
        tbl[2]  = '{32'h2096,  16, 1, 0, 4'h2, {12'h07F, 12'h096, 12'h021}, 16'h0000, 8'd0};
        tbl[3]  = '{32'h3040,  16, 1, 0, 4'h3, {12'h040, 12'h096, 12'h021}, 16'h0000, 8'd0};
        tbl[4]  = '{32'h1FFF,  15, 0, 1, 4'h3, {12'h040, 12'h096, 12'h021}, 16'h0000, 8'd1};
        tbl[5]  = '{32'h12345, 17, 0, 1, 4'h3, {12'h040, 12'h096, 12'h021}, 16'h0000, 8'd2};
        tbl[6]  = '{32'hF001,  16, 1, 0, 4'hF, {12'h040, 12'h096, 12'h021}, 16'h0000, 8'd2};
        tbl[7]  = '{32'h0000,  16, 1, 0, 4'h0, {12'h040, 12'h096, 12'h021}, 16'h0096, 8'd2};
        tbl[8]  = '{32'hF003,  16, 0, 1, 4'h0, {12'h040, 12'h096, 12'h021}, 16'h0000, 8'd3};
        tbl[9]  = '{32'h5123,  16, 0, 1, 4'h0, {12'h040, 12'h096, 12'h021}, 16'h0000, 8'd4};
        tbl[10] = '{32'hF002,  16, 1, 0, 4'hF, {12'h040, 12'h096, 12'h021}, 16'h0000, 8'd4};
        tbl[11] = '{32'hF000,  16, 1, 0, 4'hF, {12'h040, 12'h096, 12'h021}, 16'h0040, 8'd4};
        tbl[12] = '{32'h2ABC,  16, 1, 0, 4'h2, {12'h040, 12'hABC, 12'h021}, 16'h0021, 8'd4};
        tbl[13] = '{32'h1000,  16, 1, 0, 4'h1, {12'h040, 12'hABC, 12'h000}, 16'h0000, 8'd4};

        rst = 1'b1;
        cyc(5);
        rst = 1'b0;
        cyc(5);
        @(negedge pck0);
        $display("reset regs=0x%0h miso=%0d err_count=%0d", regs_flat, miso, err_count);
        check("reset regs",       64'(regs_flat), 64'({12'd127, 12'd0, 12'd0}));
        check("reset miso",       64'(miso), 64'(0));
        check("reset err_count",  64'(err_count), 64'(0));
        check("reset cmd_code",   64'(cmd_code), 64'(0));
        check("reset cmd_strobe", 64'(cmd_strobe), 64'(0));
        check("reset frame_err",  64'(frame_err), 64'(0));

        for (int i = 0; i < 14; i++) begin
            s0 = strobe_cnt;
            f0 = ferr_cnt;
            spi_frame(tbl[i].bits, tbl[i].nbits, cap);
            @(negedge pck0);
            $display("vec %0d bits=0x%0h n=%0d strobe=%0d err=%0d code=0x%0h regs=0x%0h miso=0x%0h errs=%0d",
                     i, tbl[i].bits, tbl[i].nbits, strobe_cnt - s0, ferr_cnt - f0,
                     cmd_code, regs_flat, cap, err_count);
            check($sformatf("vec%0d strobe", i),     64'(strobe_cnt - s0), 64'(tbl[i].strobe));
            check($sformatf("vec%0d frame_err", i),  64'(ferr_cnt - f0), 64'(tbl[i].ferr));
            check($sformatf("vec%0d cmd_code", i),   64'(cmd_code), 64'(tbl[i].code));
            check($sformatf("vec%0d regs", i),       64'(regs_flat), 64'(tbl[i].regs));
            check($sformatf("vec%0d major_mode", i), 64'(major_mode), 64'(tbl[i].regs[7:5]));
            check($sformatf("vec%0d err_count", i),  64'(err_count), 64'(tbl[i].errs));
            check($sformatf("vec%0d miso", i),       64'(cap), 64'(exp_shift(tbl[i].miso, tbl[i].nbits)));
        end

        // Reset lands after 8 bits of 0x2055; ncs rises only while reset is held
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        ncs = 1'b0;
        cyc(6);
        send_bits(32'h20, 8, cap);
        rst = 1'b1;
        cyc(5);
        ncs  = 1'b1;
        mosi = 1'b0;
        cyc(10);
        rst = 1'b0;
        cyc(10);
        @(negedge pck0);
        $display("midreset strobe=%0d err=%0d regs=0x%0h errs=%0d",
                 strobe_cnt - s0, ferr_cnt - f0, regs_flat, err_count);
        check("midreset strobe",    64'(strobe_cnt - s0), 64'(0));
        check("midreset frame_err", 64'(ferr_cnt - f0), 64'(0));
        check("midreset regs",      64'(regs_flat), 64'({12'd127, 12'd0, 12'd0}));
        check("midreset err_count", 64'(err_count), 64'(0));
        check("midreset cmd_code",  64'(cmd_code), 64'(0));
        model_reset();
        check_frame("after_reset", 32'h2055, 16);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: rbits = {16'h0, 4'h0, 12'($urandom)};
                1: rbits = {16'h0, 4'h1, 12'($urandom)};
                2: rbits = {16'h0, 4'h2, 12'($urandom)};
                3: rbits = {16'h0, 4'h3, 12'($urandom)};
                4: rbits = {16'h0, 4'hF, 8'($urandom), 4'($urandom_range(0, 4))};
                default: rbits = {16'h0, 4'($urandom), 12'($urandom)};
            endcase
            sel = int'($urandom_range(0, 9));
            rn  = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            if (rn == 17) rbits = {rbits[30:0], 1'($urandom)};
            check_frame($sformatf("rand%0d", i), rbits, rn);
        end

        // Empty frames until the error counter must have saturated
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 260; i++) begin
            spi_frame(32'h0, 0, cap);
            model_frame(32'h0, 0, cap[0], cap[1], rbits);
        end
        @(negedge pck0);
        $display("saturate pulses=%0d strobes=%0d err_count=%0d", ferr_cnt - f0, strobe_cnt - s0, err_count);
        check("sat err_count", 64'(err_count), 64'(m_err));
        check("sat err_count_255", 64'(err_count), 64'(255));
        check("sat pulses",    64'(ferr_cnt - f0), 64'(260));
        check("sat strobes",   64'(strobe_cnt - s0), 64'(0));
        check_frame("post_sat_err", 32'h7000, 16);
        check_frame("post_sat_ok",  32'h2123, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
